// File: rtl/aximm_wr_to_axis_pkg.sv
// ----------------------------------------------------------------------------
// aximm_wr_to_axis_pkg
//   Shared constants and types for the AXI-MM write to AXI-Stream bridge.
//   - RESP_OKAY / RESP_SLVERR : AXI response codes used on B and R
//   - rd_state_e              : states of the error-responding read FSM
// ----------------------------------------------------------------------------
package aximm_wr_to_axis_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_e;

endpackage

// File: rtl/axi_sync_fifo.sv
// ----------------------------------------------------------------------------
// axi_sync_fifo
//   Small synchronous first-word-fall-through FIFO. o_dout shows the head
//   entry whenever o_empty is low. A push while full is accepted when a pop
//   happens in the same cycle; a pop while empty is ignored.
// Ports
//   i_clk, i_rst    clock, asynchronous active-high reset (empties the FIFO)
//   i_push, i_din   write strobe and data
//   i_pop           consume head entry
//   o_dout          head entry
//   o_full, o_empty occupancy flags
// ----------------------------------------------------------------------------
module axi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra wrap bit distinguishes full from empty.
    logic [PW:0]      r_wptr;
    logic [PW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_dout    = r_mem[r_rptr[PW-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[PW-1:0]] <= i_din;
    end

endmodule

// File: rtl/aximm_wr_to_axis.sv
// ----------------------------------------------------------------------------
// aximm_wr_to_axis
//   AXI4 slave that turns write bursts into an AXI stream. AW requests are
//   queued; W beats of the head burst pass combinationally to the stream with
//   TID = AWID; each completed burst queues one B response carrying its ID.
//   Reads are answered with ARLEN+1 SLVERR beats of zero data.
// Configuration
//   AXIMM_WR_TO_AXIS_LEN_CHECK_EN : frame bursts by AWLEN instead of WLAST,
//   report WLAST misplacement as SLVERR and pulse len_err on the last beat.
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*            write address, data and response channels
//   S_AXI_AR*/R*               read channels (always SLVERR)
//   AXIS_OUT_*                 output stream (TDATA=WDATA, TKEEP=WSTRB)
//   len_err                    (LEN_CHECK_EN only) bad-burst pulse
// ----------------------------------------------------------------------------
module aximm_wr_to_axis
    import aximm_wr_to_axis_pkg::*;
#(
    parameter int DW       = 512,
    parameter int AW       = 64,
    parameter int IDW      = 4,
    parameter int AQ_DEPTH = 4,
    parameter int BQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    // write address
    input  logic [AW-1:0]   S_AXI_AWADDR,
    input  logic [IDW-1:0]  S_AXI_AWID,
    input  logic [7:0]      S_AXI_AWLEN,
    input  logic [2:0]      S_AXI_AWSIZE,
    input  logic [1:0]      S_AXI_AWBURST,
    input  logic            S_AXI_AWLOCK,
    input  logic [3:0]      S_AXI_AWCACHE,
    input  logic [3:0]      S_AXI_AWQOS,
    input  logic [2:0]      S_AXI_AWPROT,
    input  logic            S_AXI_AWVALID,
    output logic            S_AXI_AWREADY,
    // write data
    input  logic [DW-1:0]   S_AXI_WDATA,
    input  logic [DW/8-1:0] S_AXI_WSTRB,
    input  logic            S_AXI_WLAST,
    input  logic            S_AXI_WVALID,
    output logic            S_AXI_WREADY,
    // write response
    output logic [IDW-1:0]  S_AXI_BID,
    output logic [1:0]      S_AXI_BRESP,
    output logic            S_AXI_BVALID,
    input  logic            S_AXI_BREADY,
    // read address
    input  logic [AW-1:0]   S_AXI_ARADDR,
    input  logic [IDW-1:0]  S_AXI_ARID,
    input  logic [7:0]      S_AXI_ARLEN,
    input  logic [1:0]      S_AXI_ARBURST,
    input  logic            S_AXI_ARLOCK,
    input  logic [3:0]      S_AXI_ARCACHE,
    input  logic [3:0]      S_AXI_ARQOS,
    input  logic [2:0]      S_AXI_ARPROT,
    input  logic            S_AXI_ARVALID,
    output logic            S_AXI_ARREADY,
    // read data
    output logic [DW-1:0]   S_AXI_RDATA,
    output logic [IDW-1:0]  S_AXI_RID,
    output logic [1:0]      S_AXI_RRESP,
    output logic            S_AXI_RLAST,
    output logic            S_AXI_RVALID,
    input  logic            S_AXI_RREADY,
    // stream out
    output logic [DW-1:0]   AXIS_OUT_TDATA,
    output logic [DW/8-1:0] AXIS_OUT_TKEEP,
    output logic [IDW-1:0]  AXIS_OUT_TID,
    output logic            AXIS_OUT_TLAST,
    output logic            AXIS_OUT_TVALID,
`ifdef AXIMM_WR_TO_AXIS_LEN_CHECK_EN
    output logic            len_err,
`endif
    input  logic            AXIS_OUT_TREADY
);

    // ---------------- AW queue ----------------
    logic [IDW+7:0] w_aq_dout;
    logic [IDW-1:0] w_head_id;
    logic [7:0]     w_head_len;
    logic           w_aq_full;
    logic           w_aq_empty;
    logic           w_aq_push;

    // ---------------- B queue -----------------
    logic [IDW+1:0] w_bq_dout;
    logic           w_bq_full;
    logic           w_bq_empty;
    logic           w_b_pop;

    // ---------------- W path ------------------
    logic [7:0]     r_beat_cnt;
    logic           w_go;
    logic           w_beat;
    logic           w_end_beat;
    logic           w_burst_done;
    logic [1:0]     w_resp;

    assign w_head_id  = w_aq_dout[IDW+7:8];
    assign w_head_len = w_aq_dout[7:0];

    // Ready also rises in the cycle the head burst retires, so a full queue
    // can take a new request while it pops one.
    assign S_AXI_AWREADY = ~reset & (~w_aq_full | w_burst_done);
    assign w_aq_push     = S_AXI_AWVALID & S_AXI_AWREADY;

    axi_sync_fifo #(.WIDTH(IDW+8), .DEPTH(AQ_DEPTH)) u_aq (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_push  (w_aq_push),
        .i_din   ({S_AXI_AWID, S_AXI_AWLEN}),
        .i_pop   (w_burst_done),
        .o_dout  (w_aq_dout),
        .o_full  (w_aq_full),
        .o_empty (w_aq_empty)
    );

    // Beats flow only with a known burst and room for its response; a B pop
    // in the same cycle frees that room.
    assign w_b_pop = ~w_bq_empty & S_AXI_BREADY;
    assign w_go    = ~w_aq_empty & (~w_bq_full | w_b_pop);

    assign AXIS_OUT_TVALID = S_AXI_WVALID & w_go;
    assign S_AXI_WREADY    = AXIS_OUT_TREADY & w_go;
    assign w_beat          = S_AXI_WVALID & AXIS_OUT_TREADY & w_go;
    assign AXIS_OUT_TDATA  = S_AXI_WDATA;
    assign AXIS_OUT_TKEEP  = S_AXI_WSTRB;
    assign AXIS_OUT_TID    = w_head_id;
    assign w_burst_done    = w_beat & w_end_beat;

`ifdef AXIMM_WR_TO_AXIS_LEN_CHECK_EN
    logic r_err;
    logic w_bad_beat;

    assign w_end_beat     = (r_beat_cnt == w_head_len);
    assign AXIS_OUT_TLAST = w_end_beat;
    assign w_bad_beat     = (S_AXI_WLAST != w_end_beat);
    assign w_resp         = (r_err | w_bad_beat) ? RESP_SLVERR : RESP_OKAY;
    assign len_err        = w_burst_done & (r_err | w_bad_beat);

    // Sticky per-burst record of any misplaced WLAST.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)             r_err <= 1'b0;
        else if (w_burst_done) r_err <= 1'b0;
        else if (w_beat && w_bad_beat) r_err <= 1'b1;
    end
`else
    assign w_end_beat     = S_AXI_WLAST;
    assign AXIS_OUT_TLAST = S_AXI_WLAST;
    assign w_resp         = RESP_OKAY;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)             r_beat_cnt <= '0;
        else if (w_burst_done) r_beat_cnt <= '0;
        else if (w_beat)       r_beat_cnt <= r_beat_cnt + 8'd1;
    end

    axi_sync_fifo #(.WIDTH(IDW+2), .DEPTH(BQ_DEPTH)) u_bq (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_push  (w_burst_done),
        .i_din   ({w_head_id, w_resp}),
        .i_pop   (w_b_pop),
        .o_dout  (w_bq_dout),
        .o_full  (w_bq_full),
        .o_empty (w_bq_empty)
    );

    assign S_AXI_BVALID = ~w_bq_empty;
    assign S_AXI_BID    = w_bq_dout[IDW+1:2];
    assign S_AXI_BRESP  = w_bq_dout[1:0];

    // ---------------- read FSM ----------------
    rd_state_e      r_rd_state;
    rd_state_e      w_rd_next;
    logic [7:0]     r_rcnt;
    logic [IDW-1:0] r_rid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rd_state <= RD_IDLE;
        else       r_rd_state <= w_rd_next;
    end

    always_comb begin
        w_rd_next     = r_rd_state;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        S_AXI_RLAST   = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                S_AXI_ARREADY = ~reset;
                if (S_AXI_ARVALID && !reset) w_rd_next = RD_RESP;
            end
            RD_RESP: begin
                S_AXI_RVALID = 1'b1;
                S_AXI_RLAST  = (r_rcnt == 8'd0);
                if (S_AXI_RREADY && r_rcnt == 8'd0) w_rd_next = RD_IDLE;
            end
            default: w_rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rcnt <= '0;
            r_rid  <= '0;
        end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            r_rcnt <= S_AXI_ARLEN;
            r_rid  <= S_AXI_ARID;
        end else if (S_AXI_RVALID && S_AXI_RREADY && r_rcnt != 8'd0) begin
            r_rcnt <= r_rcnt - 8'd1;
        end
    end

    assign S_AXI_RDATA = '0;
    assign S_AXI_RID   = r_rid;
    assign S_AXI_RRESP = RESP_SLVERR;

    // Address/attribute fields carry no meaning for a stream sink.
    logic w_unused;
    assign w_unused = ^{S_AXI_AWADDR, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLOCK,
                        S_AXI_AWCACHE, S_AXI_AWQOS, S_AXI_AWPROT,
                        S_AXI_ARADDR, S_AXI_ARBURST, S_AXI_ARLOCK,
                        S_AXI_ARCACHE, S_AXI_ARQOS, S_AXI_ARPROT
`ifndef AXIMM_WR_TO_AXIS_LEN_CHECK_EN
                        , w_head_len, r_beat_cnt
`endif
                       };

endmodule

// File: tb/tb_aximm_wr_to_axis.sv
module tb_aximm_wr_to_axis;

    localparam int DW  = 512;
    localparam int AW  = 64;
    localparam int IDW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [AW-1:0]   awaddr;   logic [IDW-1:0] awid;   logic [7:0] awlen;
    logic            awvalid, awready;
    logic [DW-1:0]   wdata;    logic [DW/8-1:0] wstrb; logic wlast, wvalid, wready;
    logic [IDW-1:0]  bid;      logic [1:0] bresp;      logic bvalid, bready;
    logic [IDW-1:0]  arid;     logic [7:0] arlen;      logic arvalid, arready;
    logic [DW-1:0]   rdata;    logic [IDW-1:0] rid;    logic [1:0] rresp;
    logic            rlast, rvalid, rready;
    logic [DW-1:0]   tdata;    logic [DW/8-1:0] tkeep; logic [IDW-1:0] tid;
    logic            tlast, tvalid, tready;
`ifdef AXIMM_WR_TO_AXIS_LEN_CHECK_EN
    logic            len_err;
`endif

    aximm_wr_to_axis #(.DW(DW), .AW(AW), .IDW(IDW), .AQ_DEPTH(4), .BQ_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWID(awid), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(3'd6),
        .S_AXI_AWBURST(2'b01), .S_AXI_AWLOCK(1'b0), .S_AXI_AWCACHE(4'd0), .S_AXI_AWQOS(4'd0),
        .S_AXI_AWPROT(3'd0), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR('0), .S_AXI_ARID(arid), .S_AXI_ARLEN(arlen), .S_AXI_ARBURST(2'b01),
        .S_AXI_ARLOCK(1'b0), .S_AXI_ARCACHE(4'd0), .S_AXI_ARQOS(4'd0), .S_AXI_ARPROT(3'd0),
        .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RID(rid), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .AXIS_OUT_TDATA(tdata), .AXIS_OUT_TKEEP(tkeep), .AXIS_OUT_TID(tid),
        .AXIS_OUT_TLAST(tlast), .AXIS_OUT_TVALID(tvalid),
`ifdef AXIMM_WR_TO_AXIS_LEN_CHECK_EN
        .len_err(len_err),
`endif
        .AXIS_OUT_TREADY(tready)
    );

    typedef struct packed {
        logic [DW-1:0]   d;
        logic [DW/8-1:0] k;
        logic [IDW-1:0]  id;
        logic            last;
    } sbeat_t;

    sbeat_t         exp_s[$];
    logic [IDW+1:0] exp_b[$];
    logic [IDW:0]   exp_r[$];
    sbeat_t         s_e;
    logic [IDW+1:0] b_e;
    logic [IDW:0]   r_e;
    int total = 0;
    int bad = 0;
    int len_err_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every completed handshake is matched in order.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (tvalid && tready) begin
                total++;
                if (exp_s.size() == 0) begin
                    bad++;
                    $display("FAIL stream_unexpected: got tid=%0d tlast=%0b, required no beat", tid, tlast);
                end else begin
                    s_e = exp_s.pop_front();
                    if ({tdata, tkeep, tid, tlast} !== s_e) begin
                        bad++;
                        $display("FAIL stream_beat: got tid=%0d tlast=%0b keep=%h data=%h, required tid=%0d tlast=%0b keep=%h data=%h",
                                 tid, tlast, tkeep, tdata, s_e.id, s_e.last, s_e.k, s_e.d);
                    end
                end
            end
            if (bvalid && bready) begin
                total++;
                if (exp_b.size() == 0) begin
                    bad++;
                    $display("FAIL b_unexpected: got bid=%0d bresp=%b, required none", bid, bresp);
                end else begin
                    b_e = exp_b.pop_front();
                    if ({bid, bresp} !== b_e) begin
                        bad++;
                        $display("FAIL b_resp: got bid=%0d bresp=%b, required bid=%0d bresp=%b",
                                 bid, bresp, b_e[IDW+1:2], b_e[1:0]);
                    end
                end
            end
            if (rvalid && rready) begin
                total++;
                if (exp_r.size() == 0) begin
                    bad++;
                    $display("FAIL r_unexpected: got rid=%0d rlast=%0b, required none", rid, rlast);
                end else begin
                    r_e = exp_r.pop_front();
                    if ({rid, rlast} !== r_e || rresp !== 2'b10 || rdata !== '0) begin
                        bad++;
                        $display("FAIL r_beat: got rid=%0d rlast=%0b rresp=%b data_zero=%0b, required rid=%0d rlast=%0b rresp=10 data_zero=1",
                                 rid, rlast, rresp, (rdata == '0), r_e[IDW:1], r_e[0]);
                    end
                end
            end
`ifdef AXIMM_WR_TO_AXIS_LEN_CHECK_EN
            if (len_err === 1'b1) len_err_cnt++;
`endif
        end
    end

    task automatic send_aw(input logic [IDW-1:0] id, input logic [7:0] len);
        int n = 0;
        awvalid = 1'b1; awid = id; awlen = len; awaddr = {$urandom, $urandom};
        while (awready !== 1'b1 && n < 200) begin tick(); n++; end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL aw_timeout: awready=%b, required 1", awready);
        end
        tick();
        awvalid = 1'b0;
    endtask

    // Presents one W beat and records what the stream (and B, if the beat
    // closes a burst) must show for it.
    task automatic drive_w(input logic [IDW-1:0] id, input logic wl, input logic exp_last,
                           input logic push_b, input logic [1:0] exp_resp);
        logic [DW-1:0]   d;
        logic [DW/8-1:0] k;
        for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
        k = {$urandom, $urandom};
        wdata = d; wstrb = k; wlast = wl; wvalid = 1'b1;
        exp_s.push_back({d, k, id, exp_last});
        if (push_b) exp_b.push_back({id, exp_resp});
    endtask

    task automatic send_w(input logic [IDW-1:0] id, input logic wl, input logic exp_last,
                          input logic push_b, input logic [1:0] exp_resp);
        int n = 0;
        drive_w(id, wl, exp_last, push_b, exp_resp);
        while (wready !== 1'b1 && n < 200) begin tick(); n++; end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL w_timeout: wready=%b, required 1", wready);
        end
        tick();
        wvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_s.size() != 0 || exp_b.size() != 0 || exp_r.size() != 0) && n < 100) begin
            tick(); n++;
        end
        total++;
        if (exp_s.size() != 0 || exp_b.size() != 0 || exp_r.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: outstanding s=%0d b=%0d r=%0d, required 0 0 0",
                     name, exp_s.size(), exp_b.size(), exp_r.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        awvalid = 0; awid = 0; awlen = 0; awaddr = 0;
        wvalid = 1'b1; wdata = 0; wstrb = 0; wlast = 0;
        arvalid = 0; arid = 0; arlen = 0;
        bready = 1'b1; rready = 1'b1; tready = 1'b1;
        repeat (3) tick();
        total++;
        if ({awready, wready, bvalid, rvalid, tvalid} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs: aw/w/b/r/t = %b, required 00000",
                     {awready, wready, bvalid, rvalid, tvalid});
        end
        wvalid = 1'b0;
        reset = 1'b0;
        #1;
        total++;
        if ({awready, arready} !== 2'b11) begin
            bad++;
            $display("FAIL reset_release: awready/arready = %b, required 11", {awready, arready});
        end
        tick();
    endtask

    task automatic test_basic_burst();
        send_aw(4'd3, 8'd3);
        for (int i = 0; i < 4; i++) send_w(4'd3, i == 3, i == 3, i == 3, 2'b00);
        drain("basic");
    endtask

    task automatic test_w_before_aw();
        fork
            begin
                for (int i = 0; i < 4; i++) send_w(4'd2, i == 3, i == 3, i == 3, 2'b00);
            end
            begin
                repeat (4) begin
                    tick();
                    total++;
                    if ({wready, tvalid} !== 2'b00) begin
                        bad++;
                        $display("FAIL w_held: wready/tvalid = %b, required 00", {wready, tvalid});
                    end
                end
                send_aw(4'd2, 8'd3);
            end
        join
        drain("w_before_aw");
    endtask

    task automatic test_aw_full();
        for (int i = 0; i < 4; i++) send_aw(4'(i), 8'd0);
        total++;
        if (awready !== 1'b0) begin
            bad++; $display("FAIL aw_full: awready=%b, required 0", awready);
        end
        awvalid = 1'b1; awid = 4'd4; awlen = 8'd0;
        repeat (2) begin
            tick();
            total++;
            if (awready !== 1'b0) begin
                bad++; $display("FAIL aw_full_hold: awready=%b, required 0", awready);
            end
        end
        drive_w(4'd0, 1'b1, 1'b1, 1'b1, 2'b00);
        #1;
        total++;
        if (awready !== 1'b1) begin
            bad++; $display("FAIL aw_ready_on_pop: awready=%b, required 1", awready);
        end
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 1; i < 5; i++) send_w(4'(i), 1'b1, 1'b1, 1'b1, 2'b00);
        drain("aw_full");
    endtask

    task automatic test_b_backpressure();
        bready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_aw(4'(i), 8'd0);
            send_w(4'(i), 1'b1, 1'b1, 1'b1, 2'b00);
        end
        send_aw(4'd4, 8'd0);
        drive_w(4'd4, 1'b1, 1'b1, 1'b1, 2'b00);
        repeat (3) begin
            tick();
            total++;
            if ({wready, tvalid} !== 2'b00) begin
                bad++; $display("FAIL b_full_hold: wready/tvalid = %b, required 00", {wready, tvalid});
            end
        end
        bready = 1'b1;
        #1;
        total++;
        if (wready !== 1'b1) begin
            bad++; $display("FAIL b_pop_release: wready=%b, required 1", wready);
        end
        tick();
        wvalid = 1'b0;
        drain("b_backpressure");
    endtask

    task automatic test_read();
        int n = 0;
        rready = 1'b0;
        arvalid = 1'b1; arid = 4'd7; arlen = 8'd2;
        exp_r.push_back({4'd7, 1'b0});
        exp_r.push_back({4'd7, 1'b0});
        exp_r.push_back({4'd7, 1'b1});
        tick();
        arvalid = 1'b0;
        while (exp_r.size() != 0 && n < 50) begin
            rready = n[0];
            total++;
            if (arready !== 1'b0) begin
                bad++; $display("FAIL ar_busy: arready=%b, required 0", arready);
            end
            tick(); n++;
        end
        rready = 1'b1;
        total++;
        if ({arready, rvalid, exp_r.size() == 0} !== 3'b101) begin
            bad++;
            $display("FAIL read_done: arready=%b rvalid=%b left=%0d, required 1 0 0",
                     arready, rvalid, exp_r.size());
        end
    endtask

    task automatic test_len_mismatch();
        send_aw(4'd5, 8'd3);
`ifdef AXIMM_WR_TO_AXIS_LEN_CHECK_EN
        send_w(4'd5, 1'b0, 1'b0, 1'b0, 2'b00);
        send_w(4'd5, 1'b1, 1'b0, 1'b0, 2'b00);
        send_w(4'd5, 1'b0, 1'b0, 1'b0, 2'b00);
        send_w(4'd5, 1'b0, 1'b1, 1'b1, 2'b10);
        drain("len_mismatch");
        total++;
        if (len_err_cnt != 1) begin
            bad++; $display("FAIL len_err_pulses: got %0d, required 1", len_err_cnt);
        end
`else
        // WLAST alone frames the burst, so it ends on the second beat.
        send_w(4'd5, 1'b0, 1'b0, 1'b0, 2'b00);
        send_w(4'd5, 1'b1, 1'b1, 1'b1, 2'b00);
        drain("len_mismatch");
`endif
    endtask

    task automatic test_reset_mid_burst();
        send_aw(4'd9, 8'd3);
        send_w(4'd9, 1'b0, 1'b0, 1'b0, 2'b00);
        send_w(4'd9, 1'b0, 1'b0, 1'b0, 2'b00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wvalid = 1'b1; wlast = 1'b0;
        tick();
        total++;
        if ({tvalid, wready, bvalid} !== 3'b000) begin
            bad++;
            $display("FAIL reset_discard: tvalid/wready/bvalid = %b, required 000", {tvalid, wready, bvalid});
        end
        wvalid = 1'b0;
        send_aw(4'd10, 8'd0);
        send_w(4'd10, 1'b1, 1'b1, 1'b1, 2'b00);
        drain("after_reset");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_burst();
        test_w_before_aw();
        test_aw_full();
        test_b_backpressure();
        test_read();
        test_len_mismatch();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
